mips_loader: RTL and testbench

Boot-time program loader and post-run register dumper for the `MIPS_32` core. It accepts instruction words over a valid/ready stream and writes them into program memory from address 0 while holding the core in reset. It then releases the core, waits for HALT, and streams the register file out over a second valid/ready stream. This replaces hierarchical memory and register pokes with a synthesizable front end.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/mips_watchdog.sv | 32 +++
 rtl/mips_loader.sv | 155 +++++++++++++++
 tb/tb_mips_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mips_pkg : shared state encoding and constants for mips_loader         |
// | Revision : 1.0                                                          |
// +-----------------------------------------------------------------------+
package mips_pkg;

  localparam int REG_AW = 5;
  localparam logic [31:0] HALT_OPCODE = 32'hfc000000;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_RUN   = 3'd2,
    ST_DUMP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mips_watchdog.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mips_watchdog : saturating RUN-cycle counter with expiry flag          |
// | Revision : 1.0                                                          |
// +-----------------------------------------------------------------------+
module mips_watchdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk1,
  input  logic reset,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt;

  // Saturates at the limit so expiry stays asserted until cleared.
  always_ff @(posedge clk1) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == LIMIT) && !clear;

endmodule
`default_nettype wire

// File: rtl/mips_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mips_loader : boot program loader and post-HALT register dumper        |
// | Optional run watchdog enabled by defining MIPS_LOADER_WDOG_EN.         |
// | Revision : 1.0                                                          |
// +-----------------------------------------------------------------------+
module mips_loader
  import mips_pkg::*;
#(
  parameter int MEM_AW      = 10,
  parameter int NREG        = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  input  logic              cpu_halted,
  output logic [REG_AW-1:0] reg_raddr,
  input  logic [31:0]       reg_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_data,
  output logic              m_last,
  output logic              done,
  output logic              err
);

  localparam logic [MEM_AW-1:0] ADDR_MAX = '1;
  localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NREG - 1);

  state_t            state;
  state_t            state_nx;
  logic [MEM_AW-1:0] addr_cnt;
  logic [REG_AW-1:0] reg_idx;
  logic              armed;
  logic              err_r;
  logic              load_hs;
  logic              load_end;
  logic              dump_hs;
  logic              wdog_expire;

`ifdef MIPS_LOADER_WDOG_EN
  mips_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk1    (clk1),
    .reset   (reset),
    .clear   (state != ST_RUN),
    .expired (wdog_expire)
  );
`else
  logic unused_timeout;
  assign wdog_expire    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk1) begin
    if (reset) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    cpu_rst  = 1'b0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    done     = 1'b0;
    load_hs  = 1'b0;
    load_end = 1'b0;
    dump_hs  = 1'b0;
    case (state)
      ST_LOAD: begin
        // armed keeps s_ready low through the first cycle after reset.
        s_ready  = armed;
        cpu_rst  = 1'b1;
        load_hs  = s_valid && armed;
        load_end = load_hs && (s_last || (addr_cnt == ADDR_MAX));
        if (load_end) begin
          state_nx = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        cpu_rst  = 1'b1;
        state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (cpu_halted || wdog_expire) begin
          state_nx = ST_DUMP;
        end
      end
      ST_DUMP: begin
        m_valid = 1'b1;
        m_last  = (reg_idx == LAST_IDX);
        dump_hs = m_ready;
        if (dump_hs && m_last) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        cpu_rst  = 1'b1;
        state_nx = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      armed     <= 1'b0;
      addr_cnt  <= '0;
      reg_idx   <= '0;
      err_r     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      armed  <= 1'b1;
      mem_we <= load_hs;
      if (load_hs) begin
        mem_addr  <= addr_cnt;
        mem_wdata <= s_data;
        addr_cnt  <= addr_cnt + MEM_AW'(1);
      end
      // A word forced to be last by a full memory is an overflow.
      if (load_hs && (addr_cnt == ADDR_MAX) && !s_last) begin
        err_r <= 1'b1;
      end
      if ((state == ST_RUN) && !cpu_halted && wdog_expire) begin
        err_r <= 1'b1;
      end
      if (dump_hs && !m_last) begin
        reg_idx <= reg_idx + REG_AW'(1);
      end
    end
  end

  assign reg_raddr = reg_idx;
  assign m_data    = reg_rdata;
  assign err       = err_r;

endmodule
`default_nettype wire

// File: tb/tb_mips_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mips_loader : directed self-checking bench for mips_loader          |
// | Revision : 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_mips_loader;
  import mips_pkg::*;

  localparam int AW = 10;

  logic          clk1 = 1'b0;
  logic          reset, s_valid, s_last, cpu_halted, m_ready;
  logic [31:0]   s_data;
  logic          s_ready, mem_we, cpu_rst, m_valid, m_last, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, reg_rdata, m_data;
  logic [4:0]    reg_raddr;

  logic          reset_s, s_valid_s, s_last_s, cpu_halted_s, m_ready_s;
  logic [31:0]   s_data_s;
  logic          s_ready_s, mem_we_s, cpu_rst_s, m_valid_s, m_last_s, done_s, err_s;
  logic [1:0]    mem_addr_s;
  logic [31:0]   mem_wdata_s, reg_rdata_s, m_data_s;
  logic [4:0]    reg_raddr_s;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]   regs [32];
  logic [31:0]   prog [10];
  logic [AW-1:0] wr_addr [$];
  logic [31:0]   wr_data [$];
  logic [1:0]    wr_addr_s [$];
  logic [31:0]   wr_data_s [$];

  always #5 clk1 = ~clk1;

  mips_loader #(.MEM_AW(AW), .NREG(32), .TIMEOUT_CYC(50)) dut (
    .clk1(clk1), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .cpu_halted(cpu_halted),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .done(done), .err(err)
  );

  mips_loader #(.MEM_AW(2), .NREG(32), .TIMEOUT_CYC(50)) dut_s (
    .clk1(clk1), .reset(reset_s), .s_valid(s_valid_s), .s_ready(s_ready_s),
    .s_data(s_data_s), .s_last(s_last_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
    .mem_wdata(mem_wdata_s), .cpu_rst(cpu_rst_s), .cpu_halted(cpu_halted_s),
    .reg_raddr(reg_raddr_s), .reg_rdata(reg_rdata_s), .m_valid(m_valid_s),
    .m_ready(m_ready_s), .m_data(m_data_s), .m_last(m_last_s), .done(done_s), .err(err_s)
  );

  // Register file model of the halted core after running the program.
  assign reg_rdata   = regs[reg_raddr];
  assign reg_rdata_s = regs[reg_raddr_s];

  always @(negedge clk1) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (mem_we_s) begin
      wr_addr_s.push_back(mem_addr_s);
      wr_data_s.push_back(mem_wdata_s);
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Streams prog[0..n-1], s_last on the final word; returns at RUN entry.
  task automatic load_prog(input int n, input bit gaps);
    int i = 0;
    int budget = 200;
    while (i < n && budget > 0) begin
      s_valid = gaps ? (((i + budget) % 3) != 0) : 1'b1;
      s_data  = prog[i];
      s_last  = (i == n - 1);
      if (s_valid && s_ready) i++;
      tick();
      budget--;
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    vectors++;
    if (i !== n) begin
      miscompares++;
      $display("FAIL load_accept: accepted %0d words, required %0d", i, n);
    end
    vectors++;
    if ({cpu_rst, mem_we, mem_addr, mem_wdata, s_ready} !== {1'b1, 1'b1, AW'(n - 1), prog[n-1], 1'b0}) begin
      miscompares++;
      $display("FAIL flush_cycle: rst/we/addr/data/rdy=%b/%b/%0d/%h/%b required 1/1/%0d/%h/0",
               cpu_rst, mem_we, mem_addr, mem_wdata, s_ready, n - 1, prog[n-1]);
    end
    tick();
    vectors++;
    if ({cpu_rst, mem_we} !== 2'b00) begin
      miscompares++;
      $display("FAIL run_entry: cpu_rst/mem_we=%b/%b required 0/0", cpu_rst, mem_we);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; reset_s = 1'b1;
    tick(); tick();
    vectors++;
    if ({s_ready, mem_we, mem_addr, mem_wdata, cpu_rst, reg_raddr, m_valid, m_last, done, err}
        !== {2'b00, 10'd0, 32'd0, 1'b1, 5'd0, 4'b0000}) begin
      miscompares++;
      $display("FAIL reset_vals: rdy=%b we=%b addr=%0d wd=%h crst=%b ra=%0d mv=%b ml=%b dn=%b er=%b",
               s_ready, mem_we, mem_addr, mem_wdata, cpu_rst, reg_raddr, m_valid, m_last, done, err);
    end
    vectors++;
    if ({s_ready_s, mem_we_s, cpu_rst_s, m_valid_s, done_s, err_s} !== 6'b001000) begin
      miscompares++;
      $display("FAIL reset_vals_small: got %b required 001000",
               {s_ready_s, mem_we_s, cpu_rst_s, m_valid_s, done_s, err_s});
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_after_reset: s_ready=%b required 0", s_ready);
    end
    tick();
    vectors++;
    if (s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_rise: s_ready=%b required 1", s_ready);
    end
  endtask

  task automatic test_load();
    wr_addr.delete(); wr_data.delete();
    load_prog(10, 1'b1);
    vectors++;
    if (wr_addr.size() !== 10) begin
      miscompares++;
      $display("FAIL write_count: %0d writes, required 10", wr_addr.size());
    end
    for (int k = 0; k < 10 && k < wr_addr.size(); k++) begin
      vectors++;
      if ({wr_addr[k], wr_data[k]} !== {AW'(k), prog[k]}) begin
        miscompares++;
        $display("FAIL write_%0d: addr/data=%0d/%h required %0d/%h", k, wr_addr[k], wr_data[k], k, prog[k]);
      end
    end
  endtask

  task automatic test_dump();
    tick(); tick(); tick();
    vectors++;
    if ({m_valid, cpu_rst, s_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL run_idle: mv/crst/rdy=%b required 000", {m_valid, cpu_rst, s_ready});
    end
    cpu_halted = 1'b1;
    m_ready    = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if ({m_valid, reg_raddr, m_data, m_last} !== {1'b1, 5'(i), regs[i], (i == 31)}) begin
        miscompares++;
        $display("FAIL dump_R%0d: mv/ra/data/last=%b/%0d/%h/%b required 1/%0d/%h/%b",
                 i, m_valid, reg_raddr, m_data, m_last, i, regs[i], (i == 31));
      end
      tick();
    end
    tick(); tick();
    vectors++;
    if ({done, err, m_valid, s_ready, cpu_rst} !== 5'b10000) begin
      miscompares++;
      $display("FAIL done_state: done/err/mv/rdy/crst=%b required 10000",
               {done, err, m_valid, s_ready, cpu_rst});
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_midload();
    reset = 1'b1; cpu_halted = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    wr_addr.delete(); wr_data.delete();
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = prog[k]; s_last = 1'b0;
      tick();
    end
    s_valid = 1'b0; s_data = '0;
    reset = 1'b1;
    tick();
    vectors++;
    if ({s_ready, mem_we, mem_addr, mem_wdata, cpu_rst, reg_raddr, m_valid, m_last, done, err}
        !== {2'b00, 10'd0, 32'd0, 1'b1, 5'd0, 4'b0000}) begin
      miscompares++;
      $display("FAIL midload_reset_vals: rdy=%b we=%b addr=%0d wd=%h crst=%b ra=%0d mv=%b dn=%b er=%b",
               s_ready, mem_we, mem_addr, mem_wdata, cpu_rst, reg_raddr, m_valid, done, err);
    end
    vectors++;
    if (wr_addr.size() !== 3) begin
      miscompares++;
      $display("FAIL midload_writes: %0d writes before reset, required 3", wr_addr.size());
    end
    reset = 1'b0;
    tick();
    wr_addr.delete(); wr_data.delete();
    load_prog(1, 1'b0);
    tick();
    vectors++;
    if ({wr_addr.size() == 1, (wr_addr.size() > 0) ? wr_addr[0] : AW'(1)} !== {1'b1, AW'(0)}) begin
      miscompares++;
      $display("FAIL single_word: %0d writes, first addr nonzero or missing, required one write at 0",
               wr_addr.size());
    end
  endtask

  task automatic test_dump_stalls();
    int e = 0;
    int budget = 400;
    cpu_halted = 1'b1;
    while (!done && budget > 0) begin
      if (m_valid) begin
        vectors++;
        if ({reg_raddr, m_data, m_last} !== {5'(e), regs[e], (e == 31)}) begin
          miscompares++;
          $display("FAIL stall_dump_%0d: ra/data/last=%0d/%h/%b required %0d/%h/%b",
                   e, reg_raddr, m_data, m_last, e, regs[e], (e == 31));
        end
      end
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid && m_ready) e++;
      tick();
      budget--;
    end
    m_ready = 1'b0;
    vectors++;
    if ({e == 32, done, err} !== 3'b110) begin
      miscompares++;
      $display("FAIL stall_done: words=%0d done=%b err=%b required 32/1/0", e, done, err);
    end
  endtask

  task automatic test_overflow();
    int acc = 0;
    tick();
    reset_s = 1'b0;
    tick();
    wr_addr_s.delete(); wr_data_s.delete();
    for (int c = 0; c < 10; c++) begin
      s_valid_s = 1'b1;
      s_last_s  = 1'b0;
      s_data_s  = prog[(acc < 4) ? acc : 4];
      if (s_ready_s) acc++;
      tick();
    end
    s_valid_s = 1'b0;
    vectors++;
    if (acc !== 4) begin
      miscompares++;
      $display("FAIL ovf_accepts: accepted %0d, required 4", acc);
    end
    vectors++;
    if (wr_addr_s.size() !== 4) begin
      miscompares++;
      $display("FAIL ovf_write_count: %0d writes, required 4", wr_addr_s.size());
    end
    for (int k = 0; k < 4 && k < wr_addr_s.size(); k++) begin
      vectors++;
      if ({wr_addr_s[k], wr_data_s[k]} !== {2'(k), prog[k]}) begin
        miscompares++;
        $display("FAIL ovf_write_%0d: addr/data=%0d/%h required %0d/%h", k, wr_addr_s[k], wr_data_s[k], k, prog[k]);
      end
    end
    vectors++;
    if ({err_s, cpu_rst_s, s_ready_s, m_valid_s, done_s} !== 5'b10000) begin
      miscompares++;
      $display("FAIL ovf_state: err/crst/rdy/mv/done=%b required 10000",
               {err_s, cpu_rst_s, s_ready_s, m_valid_s, done_s});
    end
  endtask

`ifdef MIPS_LOADER_WDOG_EN
  task automatic test_watchdog();
    int budget = 200;
    reset = 1'b1; cpu_halted = 1'b0; m_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    load_prog(2, 1'b0);
    repeat (50) tick();
    vectors++;
    if ({m_valid, err} !== 2'b00) begin
      miscompares++;
      $display("FAIL wdog_early: mv/err=%b required 00", {m_valid, err});
    end
    tick();
    vectors++;
    if ({m_valid, err, cpu_rst} !== 3'b110) begin
      miscompares++;
      $display("FAIL wdog_expire: mv/err/crst=%b required 110", {m_valid, err, cpu_rst});
    end
    m_ready = 1'b1;
    while (!done && budget > 0) begin
      tick();
      budget--;
    end
    m_ready = 1'b0;
    vectors++;
    if ({done, err} !== 2'b11) begin
      miscompares++;
      $display("FAIL wdog_dump_done: done/err=%b required 11", {done, err});
    end
  endtask
`endif

  initial begin
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h20000008,
             32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800, HALT_OPCODE};
    for (int i = 0; i < 32; i++) regs[i] = 32'h0000_0100 + 32'(i);
    regs[0] = 32'd0;  regs[1] = 32'd10; regs[2] = 32'd20;
    regs[3] = 32'd25; regs[4] = 32'd30; regs[5] = 32'd55;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; cpu_halted = 1'b0; m_ready = 1'b0;
    s_valid_s = 1'b0; s_last_s = 1'b0; s_data_s = '0; cpu_halted_s = 1'b0; m_ready_s = 1'b0;
    reset = 1'b1; reset_s = 1'b1;

    test_reset();
    test_load();
    test_dump();
    test_reset_midload();
    test_dump_stalls();
    test_overflow();
`ifdef MIPS_LOADER_WDOG_EN
    test_watchdog();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL sim_timeout: bench did not finish, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
